// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit_if
// Purpose  : Instruction-memory req/ack port plus the decode-facing
//            valid/ready output register of the fetch stage.
// Revision : 1.0
// ============================================================================
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc,
        input  imem_ack, imem_rdata, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc,
        output imem_ack, imem_rdata, id_ready
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Fetch stage; steers the always-loading PC register, runs the
//            imem port, one-deep skid buffer and redirect/flush handling.
// Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic [31:0] pc_cur,
    output logic      [31:0] pc_next,
    fetch_unit_if.master     bus,
    input  wire logic        redirect_valid,
    input  wire logic [31:0] redirect_pc,
    output logic             fetch_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_KILL  = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_req_addr;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic        r_fetch_err;
    logic        w_imem_req;

    logic [31:0] w_target;
    logic        w_redirect;
    logic        w_slot_free;
    logic        w_fetch_ack;
    logic        w_load_mem;
    logic        w_to_skid;
    logic        w_release;
    logic        w_kill_done;

    // A redirect in the IDLE cycle after reset is ignored.
    assign w_redirect  = redirect_valid && (r_state != S_IDLE);
    assign w_target    = {redirect_pc[31:2], 2'b00};
    assign w_slot_free = !r_if_valid || bus.id_ready;
    assign w_fetch_ack = (r_state == S_FETCH) && bus.imem_ack;
    assign w_load_mem  = w_fetch_ack && w_slot_free && !w_redirect;
    assign w_to_skid   = w_fetch_ack && !w_slot_free && !w_redirect;
    assign w_release   = (r_state == S_HOLD) && bus.id_ready && !w_redirect;
    assign w_kill_done = (r_state == S_KILL) && bus.imem_ack && !w_redirect;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (w_redirect) begin
                    w_state_nxt = bus.imem_ack ? S_FETCH : S_KILL;
                end else if (w_to_skid) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_redirect || bus.id_ready) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_KILL: begin
                if (w_kill_done) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_imem_req = (r_state == S_FETCH) || (r_state == S_KILL);
    end

    // The PC register loads every cycle, so "hold" means echoing pc_cur back.
    always_comb begin
        pc_next = pc_cur;
        if (!rst_n) begin
            pc_next = RESET_PC;
        end else if (w_redirect) begin
            pc_next = w_target;
        end else if (w_load_mem) begin
            pc_next = r_req_addr + PC_INC;
        end else if (w_release) begin
            pc_next = r_skid_pc + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_req_addr   <= RESET_PC;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'h0;
            r_if_pc      <= 32'h0;
            r_skid_instr <= 32'h0;
            r_skid_pc    <= 32'h0;
            r_fetch_err  <= 1'b0;
        end else begin
            if (r_if_valid && bus.id_ready) begin
                r_if_valid <= 1'b0;
            end
            if (w_redirect) begin
                r_if_valid <= 1'b0;
                if (redirect_pc[1:0] != 2'b00) begin
                    r_fetch_err <= 1'b1;
                end
                // KILL keeps the stale address; the target arrives later via pc_cur.
                if (w_fetch_ack || (r_state == S_HOLD)) begin
                    r_req_addr <= w_target;
                end
            end else if (w_load_mem) begin
                r_if_valid <= 1'b1;
                r_if_instr <= bus.imem_rdata;
                r_if_pc    <= r_req_addr;
                r_req_addr <= r_req_addr + PC_INC;
            end else if (w_to_skid) begin
                r_skid_instr <= bus.imem_rdata;
                r_skid_pc    <= r_req_addr;
            end else if (w_release) begin
                r_if_valid <= 1'b1;
                r_if_instr <= r_skid_instr;
                r_if_pc    <= r_skid_pc;
                r_req_addr <= r_skid_pc + PC_INC;
            end else if (w_kill_done) begin
                r_req_addr <= pc_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && ((r_state == S_FETCH) || (r_state == S_HOLD)) && !redirect_valid) begin
            assert (pc_cur == r_req_addr);
        end
    end

    assign bus.imem_req  = w_imem_req;
    assign bus.imem_addr = r_req_addr;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;
    assign fetch_err     = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit with a PC register in the loop.
// Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    logic        clk            = 1'b0;
    logic        rst_n          = 1'b0;
    logic [31:0] pc_cur         = RESET_PC;
    logic [31:0] pc_next;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        fetch_err;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .PC_INC(PC_INC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_cur         (pc_cur),
        .pc_next        (pc_next),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pc_cur <= pc_next;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_0F96;
    endfunction

    // Memory model: mode 0 manual ack, 1 fixed latency, 2 random ack.
    int   mem_mode  = 0;
    int   mem_lat   = 0;
    int   wait_cnt  = 0;
    logic ack_man   = 1'b0;
    logic rand_ack  = 1'b0;
    logic ready_drv = 1'b1;

    assign bus.id_ready   = ready_drv;
    assign bus.imem_ack   = bus.imem_req && ((mem_mode == 0) ? ack_man :
                                             (mem_mode == 1) ? (wait_cnt >= mem_lat) : rand_ack);
    assign bus.imem_rdata = bus.imem_ack ? instr_of(bus.imem_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (!bus.imem_req || bus.imem_ack) wait_cnt <= 0;
        else                               wait_cnt <= wait_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        ack;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [31:0] addr;
        logic [31:0] pcn;
        logic        vld;
        logic [31:0] ipc;
        logic        err;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic y, input logic a, input logic d,
                                input logic [31:0] rp, input logic q, input logic [31:0] ad,
                                input logic [31:0] pn, input logic v, input logic [31:0] ip,
                                input logic e);
        vec_t t;
        t.rst_n = r; t.rdy = y; t.ack = a; t.redir = d; t.rpc = rp;
        t.req = q; t.addr = ad; t.pcn = pn; t.vld = v; t.ipc = ip; t.err = e;
        return t;
    endfunction

    // Stream-level reference: accepted instructions must walk the address
    // sequence from reset or the latest redirect target, one word at a time.
    logic        mon_en   = 1'b0;
    int          m_acc    = 0;
    logic [31:0] m_exp_pc;
    logic        m_exp_err;
    logic        m_flush;
    logic        m_idle;
    logic        m_prev_req;
    logic        m_prev_ack;
    logic [31:0] m_prev_addr;
    int          m_stall;

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!rst_n) begin
                    check("rand_rst_pc_next", pc_next, RESET_PC);
                    m_exp_pc   = RESET_PC;
                    m_exp_err  = 1'b0;
                    m_flush    = 1'b0;
                    m_idle     = 1'b1;
                    m_prev_req = 1'b0;
                    m_stall    = 0;
                end else begin
                    if (m_flush) check("rand_flush_valid", 32'(bus.if_valid), 32'd0);
                    m_flush = 1'b0;
                    check("rand_fetch_err", 32'(fetch_err), 32'(m_exp_err));
                    if (m_prev_req && !m_prev_ack && bus.imem_req)
                        check("rand_addr_stable", bus.imem_addr, m_prev_addr);
                    if (bus.if_valid && bus.id_ready) begin
                        check("rand_accept_pc", bus.if_pc, m_exp_pc);
                        check("rand_accept_instr", bus.if_instr, instr_of(bus.if_pc));
                        m_exp_pc = m_exp_pc + PC_INC;
                        m_stall  = 0;
                        m_acc++;
                    end else begin
                        m_stall++;
                    end
                    if (redirect_valid && !m_idle) begin
                        check("rand_redirect_pc_next", pc_next, {redirect_pc[31:2], 2'b00});
                        m_exp_pc = {redirect_pc[31:2], 2'b00};
                        if (redirect_pc[1:0] != 2'b00) m_exp_err = 1'b1;
                        m_flush = 1'b1;
                    end
                    m_prev_req  = bus.imem_req;
                    m_prev_ack  = bus.imem_ack;
                    m_prev_addr = bus.imem_addr;
                    m_idle      = 1'b0;
                    if (m_stall > 200) begin
                        check("rand_progress_timeout", 32'(m_stall), 32'd0);
                        m_stall = 0;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vec[21];
    logic found;
    int   cool;

    initial begin
        //        rst rdy ack rdr rpc           req addr          pc_next       vld if_pc         err
        vec[0]  = mk(0, 1, 1, 0, 32'h0,     0, 32'h0,     32'h0,     0, 32'h0,     0);
        vec[1]  = mk(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h0,     0, 32'h0,     0);
        vec[2]  = mk(1, 1, 1, 0, 32'h0,     1, 32'h0,     32'h4,     0, 32'h0,     0);
        vec[3]  = mk(1, 1, 1, 0, 32'h0,     1, 32'h4,     32'h8,     1, 32'h0,     0);
        vec[4]  = mk(1, 1, 1, 0, 32'h0,     1, 32'h8,     32'hC,     1, 32'h4,     0);
        vec[5]  = mk(1, 0, 1, 0, 32'h0,     1, 32'hC,     32'hC,     1, 32'h8,     0);
        vec[6]  = mk(1, 0, 0, 0, 32'h0,     0, 32'hC,     32'hC,     1, 32'h8,     0);
        vec[7]  = mk(1, 1, 0, 0, 32'h0,     0, 32'hC,     32'h10,    1, 32'h8,     0);
        vec[8]  = mk(1, 1, 0, 0, 32'h0,     1, 32'h10,    32'h10,    1, 32'hC,     0);
        vec[9]  = mk(1, 1, 0, 0, 32'h0,     1, 32'h10,    32'h10,    0, 32'hC,     0);
        vec[10] = mk(1, 1, 0, 1, 32'h102,   1, 32'h10,    32'h100,   0, 32'hC,     0);
        vec[11] = mk(1, 1, 0, 0, 32'h0,     1, 32'h10,    32'h100,   0, 32'hC,     1);
        vec[12] = mk(1, 1, 1, 0, 32'h0,     1, 32'h10,    32'h100,   0, 32'hC,     1);
        vec[13] = mk(1, 1, 1, 0, 32'h0,     1, 32'h100,   32'h104,   0, 32'hC,     1);
        vec[14] = mk(1, 1, 1, 1, 32'h200,   1, 32'h104,   32'h200,   1, 32'h100,   1);
        vec[15] = mk(1, 1, 1, 0, 32'h0,     1, 32'h200,   32'h204,   0, 32'h100,   1);
        vec[16] = mk(1, 0, 1, 0, 32'h0,     1, 32'h204,   32'h204,   1, 32'h200,   1);
        vec[17] = mk(1, 0, 0, 1, 32'h300,   0, 32'h204,   32'h300,   1, 32'h200,   1);
        vec[18] = mk(1, 1, 1, 0, 32'h0,     1, 32'h300,   32'h304,   0, 32'h200,   1);
        vec[19] = mk(0, 1, 1, 0, 32'h0,     1, 32'h304,   32'h0,     1, 32'h300,   1);
        vec[20] = mk(1, 1, 1, 0, 32'h0,     0, 32'h0,     32'h0,     0, 32'h0,     0);

        mem_mode = 0;
        rst_n    = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 21; i++) begin
            rst_n          = vec[i].rst_n;
            ready_drv      = vec[i].rdy;
            ack_man        = vec[i].ack;
            redirect_valid = vec[i].redir;
            redirect_pc    = vec[i].rpc;
            @(negedge clk);
            check($sformatf("row%0d_imem_req", i),  32'(bus.imem_req),  32'(vec[i].req));
            check($sformatf("row%0d_imem_addr", i), bus.imem_addr,      vec[i].addr);
            check($sformatf("row%0d_pc_next", i),   pc_next,            vec[i].pcn);
            check($sformatf("row%0d_if_valid", i),  32'(bus.if_valid),  32'(vec[i].vld));
            check($sformatf("row%0d_if_pc", i),     bus.if_pc,          vec[i].ipc);
            check($sformatf("row%0d_fetch_err", i), 32'(fetch_err),     32'(vec[i].err));
            if (vec[i].vld)
                check($sformatf("row%0d_if_instr", i), bus.if_instr, instr_of(vec[i].ipc));
            tick();
        end
        redirect_valid = 1'b0;

        // Wait states: two idle cycles before each ack.
        rst_n     = 1'b0;
        ready_drv = 1'b1;
        mem_mode  = 1;
        mem_lat   = 2;
        repeat (2) tick();
        rst_n = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.imem_req && bus.imem_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
        end
        check("ws_reached_0x10", 32'(found), 32'd1);
        check("ws_c0_pc_next", pc_next, 32'h10);
        check("ws_c0_ack", 32'(bus.imem_ack), 32'd0);
        @(negedge clk);
        check("ws_c1_addr", bus.imem_addr, 32'h10);
        check("ws_c1_pc_next", pc_next, 32'h10);
        @(negedge clk);
        check("ws_c2_addr", bus.imem_addr, 32'h10);
        check("ws_c2_ack", 32'(bus.imem_ack), 32'd1);
        check("ws_c2_pc_next", pc_next, 32'h14);
        @(negedge clk);
        check("ws_load_if_pc", bus.if_pc, 32'h10);
        check("ws_load_if_instr", bus.if_instr, instr_of(32'h10));
        check("ws_next_addr", bus.imem_addr, 32'h14);

        // Redirect with request outstanding, then reset dropped mid-cycle in KILL.
        tick();
        mem_mode       = 0;
        ack_man        = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        check("kill_redirect_pc_next", pc_next, 32'h40);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("kill_req", 32'(bus.imem_req), 32'd1);
        check("kill_old_addr", bus.imem_addr, 32'h14);
        check("kill_flushed", 32'(bus.if_valid), 32'd0);
        check("kill_pc_next_hold", pc_next, 32'h40);
        @(posedge clk);
        #2;
        ack_man = 1'b1;
        rst_n   = 1'b0;
        #1;
        check("midrst_req_unchanged", 32'(bus.imem_req), 32'd1);
        check("midrst_addr_unchanged", bus.imem_addr, 32'h14);
        check("midrst_pc_next", pc_next, RESET_PC);
        tick();
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, RESET_PC);
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_pc_cur", pc_cur, RESET_PC);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_late_ack_ignored_req", 32'(bus.imem_req), 32'd0);
        check("idle_pc_next", pc_next, RESET_PC);
        tick();
        @(negedge clk);
        check("restart_addr", bus.imem_addr, RESET_PC);
        check("restart_pc_next", pc_next, RESET_PC + PC_INC);

        // Address wrap.
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_redirect_pc_next", pc_next, 32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        check("wrap_pc_next", pc_next, 32'h0);
        check("wrap_flushed", 32'(bus.if_valid), 32'd0);
        tick();
        @(negedge clk);
        check("wrap_addr_zero", bus.imem_addr, 32'h0);
        check("wrap_if_pc_top", bus.if_pc, 32'hFFFF_FFFC);
        tick();
        @(negedge clk);
        check("wrap_if_pc_zero", bus.if_pc, 32'h0);
        check("wrap_no_err", 32'(fetch_err), 32'd0);

        // Randomized run against the stream model.
        tick();
        mem_mode = 2;
        rst_n    = 1'b0;
        mon_en   = 1'b1;
        tick();
        cool = 2;
        for (int c = 0; c < 3000; c++) begin
            rst_n          = ($urandom % 700) != 0;
            ready_drv      = ($urandom % 4) != 0;
            rand_ack       = ($urandom % 3) != 0;
            redirect_valid = 1'b0;
            if (!rst_n) begin
                cool = 2;
            end else if (cool > 0) begin
                cool--;
            end else if (($urandom % 30) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom;
                if (($urandom % 4) != 0) redirect_pc[1:0] = 2'b00;
            end
            tick();
        end
        redirect_valid = 1'b0;
        @(negedge clk);
        mon_en = 1'b0;
        check("rand_accept_count_min", 32'(m_acc > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
